alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Two-requester round-robin controller that shares a single combinational fixed-point `ALU` between independent clients. Each client submits an operand set (A, B, Cin) over a valid/ready handshake. The controller registers the operands, drives them into the ALU, captures `Out1`/`Cout`/`Out2` after one settle cycle, and returns the result tagged with the requester ID. It sits between the client blocks and the `ALU` instance, which only ever sees stable, registered operands.

## Interface
- `W`, default 4: operand width; `Out1` is `W` bits, `Out2` is `2*W` bits.
- `clk`: input, 1 bit. Single clock; all state updates on its rising edge.
- `rst_n`: input, 1 bit. Synchronous, active-low reset.
- `req_valid`: input, 2 bits. Per-requester request valid.
- `req_ready`: output, 2 bits. Per-requester accept strobe.
- `req_a0`, `req_b0`: input, `W` bits each. Requester 0 operands.
- `req_cin0`: input, 1 bit. Requester 0 carry-in.
- `req_a1`, `req_b1`: input, `W` bits each. Requester 1 operands.
- `req_cin1`: input, 1 bit. Requester 1 carry-in.
- `alu_a`, `alu_b`: output, `W` bits each. Connect to ALU `A`/`B`.
- `alu_cin`: output, 1 bit. Connect to ALU `Cin`.
- `alu_out1`: input, `W` bits. From ALU `Out1`.
- `alu_cout`: input, 1 bit. From ALU `Cout`.
- `alu_out2`: input, `2*W` bits. From ALU `Out2`.
- `rsp_valid`: output, 1 bit. Result available.
- `rsp_ready`: input, 1 bit. Consumer accepts the result.
- `rsp_id`: output, 1 bit. Requester that owns the result.
- `rsp_out1`: output, `W` bits. Captured `Out1`.
- `rsp_cout`: output, 1 bit. Captured `Cout`.
- `rsp_out2`: output, `2*W` bits. Captured `Out2`.

## Operation
- States: IDLE, EXEC, RESP.
- IDLE
  - `req_ready[i] = grant[i]`, where `grant` is the round-robin choice among the asserted `req_valid` bits.
  - On accept, the granted operands are loaded into the `alu_a`/`alu_b`/`alu_cin` registers and the owner ID is stored; next state is EXEC.
- EXEC
  - Lasts exactly one cycle; the ALU settles on the registered operands.
  - On the closing edge, `alu_out1`/`alu_cout`/`alu_out2` are captured into the `rsp_*` registers; next state is RESP.
- RESP
  - `rsp_valid = 1`; all `rsp_*` outputs are held stable until `rsp_valid && rsp_ready`, then the state returns to IDLE.
  - `req_ready = 0` in EXEC and RESP: one transaction in flight at most.
- Arbitration
  - `last` pointer records the most recently granted requester.
  - Both requesting: grant `~last`. Single requester: grant it.
  - `last` updates only on accept. Reset value `last = 1`, so requester 0 wins the first tie.
- `req_ready` is combinational from `req_valid` and the state; it never depends on `rsp_ready`.
- Requests withdrawn before being accepted are dropped without side effect.
- `alu_*` operand registers keep their last value outside EXEC; there is no ALU enable.

## Timing
- Reset: `req_ready=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_out1=0`, `rsp_cout=0`, `rsp_out2=0`, `alu_a=0`, `alu_b=0`, `alu_cin=0`, state IDLE, `last=1`.
- Latency: accept edge at cycle N gives `rsp_valid` high in cycle N+2. With `rsp_ready` held high, the next accept is at cycle N+3, so peak throughput is one operation per 3 cycles.
- `rsp_ready` high in RESP: IDLE in the next cycle. A waiting request is accepted in that IDLE cycle, with no combinational bypass from RESP.
- `rsp_ready` while `rsp_valid=0` is ignored.
- Reset asserted mid-EXEC or mid-RESP: the in-flight transaction is discarded with no response, and all outputs take their reset values on that edge.
- The ALU combinational path must settle from the `alu_*` registers to the capture registers within one `clk` period.

## Configuration
- `ALU_SHARE_STATS_EN` defined:
  - Adds outputs `grant_cnt0` and `grant_cnt1`, 8 bits each, reset to 0.
  - Counter `i` increments on each accept for requester `i` and saturates at 255.
- Not defined: the ports and counters do not exist; all other behaviour is identical.

## Structure
- Package `alu_share_pkg`: state enum (`ST_IDLE`, `ST_EXEC`, `ST_RESP`), default `W`, requester count constant 2, stats counter width 8.
- Sub-module `rr_arb2`: combinational 2-way round-robin grant from `req` and `last`, returning a one-hot grant. Pointer update stays in the parent.

## Test plan
Benches instantiate the real `ALU`; expected values are the ALU's outputs for the given operands.
- Reset, then requester 0 sends A=3, B=4, Cin=1 → `req_ready[0]` high for one cycle; two cycles later `rsp_valid=1`, `rsp_id=0`, and `rsp_*` equal the ALU outputs for (3, 4, 1).
- Both requesters valid simultaneously from reset, `rsp_ready` always high → accepts alternate 0, 1, 0, 1, spaced 3 cycles apart.
- `rsp_ready` held low for 5 cycles in RESP → `rsp_*` stable throughout; `req_ready` stays 0 even with `req_valid=2'b11`.
- Reset pulsed during EXEC → no `rsp_valid` appears; the next request completes normally with latency 2.
- Only requester 1 requesting, 4 back-to-back transactions → all granted to 1, `rsp_id=1` each time; the `last` pointer does not block repeated grants.
- With `ALU_SHARE_STATS_EN`: 300 accepts on requester 0 → `grant_cnt0=255` (saturated), `grant_cnt1=0`.

Source files
------------

// File: rtl/alu_share_pkg.sv
// alu_share_pkg: shared types and constants for the ALU-sharing controller.
//   state_e   : controller FSM states
//   W_DEF     : default operand width
//   NUM_REQ   : number of requesters served
//   STAT_W    : width of the optional per-requester grant counters
package alu_share_pkg;
    localparam int W_DEF   = 4;
    localparam int NUM_REQ = 2;
    localparam int STAT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;
endpackage

// File: rtl/alu_share_ctrl_if.sv
// alu_share_ctrl_if: bundles the request, ALU and response signals of the
// ALU-sharing controller.
//   slave  : controller side (takes requests and ALU results, drives ALU
//            operands and responses)
//   master : environment side (clients, consumer and the ALU itself)
interface alu_share_ctrl_if
    import alu_share_pkg::*;
#(
    parameter int W = W_DEF
);
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [W-1:0]       req_a0, req_b0;
    logic               req_cin0;
    logic [W-1:0]       req_a1, req_b1;
    logic               req_cin1;
    logic [W-1:0]       alu_a, alu_b;
    logic               alu_cin;
    logic [W-1:0]       alu_out1;
    logic               alu_cout;
    logic [2*W-1:0]     alu_out2;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [W-1:0]       rsp_out1;
    logic               rsp_cout;
    logic [2*W-1:0]     rsp_out2;

    modport slave (
        input  req_valid, req_a0, req_b0, req_cin0, req_a1, req_b1, req_cin1,
        input  alu_out1, alu_cout, alu_out2, rsp_ready,
        output req_ready, alu_a, alu_b, alu_cin,
        output rsp_valid, rsp_id, rsp_out1, rsp_cout, rsp_out2
    );

    modport master (
        output req_valid, req_a0, req_b0, req_cin0, req_a1, req_b1, req_cin1,
        output alu_out1, alu_cout, alu_out2, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_cin,
        input  rsp_valid, rsp_id, rsp_out1, rsp_cout, rsp_out2
    );
endinterface

// File: rtl/alu_share_ctrl_rr_arb2.sv
// rr_arb2: combinational two-way round-robin arbiter.
//   req  : request bits
//   last : most recently granted requester
//   gnt  : one-hot grant (zero when nothing requests)
// The pointer itself is owned and updated by the parent.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = req;
        // On a tie the requester that did not win last time goes next.
        if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
    end
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one combinational ALU between two requesters.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : request handshake, ALU operand/result wires, response
//                handshake (see alu_share_ctrl_if)
//   grant_cnt0/1 : saturating accept counters, present only when
//                  ALU_SHARE_STATS_EN is defined
// One transaction at a time: IDLE accepts and registers operands, EXEC lets
// the ALU settle for a cycle and captures its outputs, RESP holds the result
// until the consumer takes it.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int W = W_DEF
)(
    input  logic clk,
    input  logic rst_n,
    alu_share_ctrl_if.slave bus
`ifdef ALU_SHARE_STATS_EN
    ,
    output logic [STAT_W-1:0] grant_cnt0,
    output logic [STAT_W-1:0] grant_cnt1
`endif
);
    state_e             state_q, state_d;
    logic               last_q, last_d;
    logic               owner_q, owner_d;
    logic [W-1:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic               alu_cin_q, alu_cin_d;
    logic               rsp_id_q, rsp_id_d;
    logic [W-1:0]       rsp_out1_q, rsp_out1_d;
    logic               rsp_cout_q, rsp_cout_d;
    logic [2*W-1:0]     rsp_out2_q, rsp_out2_d;
    logic [NUM_REQ-1:0] gnt, ready;

    rr_arb2 u_arb (.req(bus.req_valid), .last(last_q), .gnt(gnt));

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_cin_d  = alu_cin_q;
        rsp_id_d   = rsp_id_q;
        rsp_out1_d = rsp_out1_q;
        rsp_cout_d = rsp_cout_q;
        rsp_out2_d = rsp_out2_q;
        ready      = '0;
        case (state_q)
            ST_IDLE: begin
                ready = gnt;
                if (gnt != '0) begin
                    alu_a_d   = gnt[1] ? bus.req_a1   : bus.req_a0;
                    alu_b_d   = gnt[1] ? bus.req_b1   : bus.req_b0;
                    alu_cin_d = gnt[1] ? bus.req_cin1 : bus.req_cin0;
                    owner_d   = gnt[1];
                    last_d    = gnt[1];
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_id_d   = owner_q;
                rsp_out1_d = bus.alu_out1;
                rsp_cout_d = bus.alu_cout;
                rsp_out2_d = bus.alu_out2;
                state_d    = ST_RESP;
            end
            ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_cin_q  <= 1'b0;
            rsp_id_q   <= 1'b0;
            rsp_out1_q <= '0;
            rsp_cout_q <= 1'b0;
            rsp_out2_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_cin_q  <= alu_cin_d;
            rsp_id_q   <= rsp_id_d;
            rsp_out1_q <= rsp_out1_d;
            rsp_cout_q <= rsp_cout_d;
            rsp_out2_q <= rsp_out2_d;
        end
    end

    // Ready is held low while reset is asserted so no client sees an
    // accept strobe that the flops will not honour.
    assign bus.req_ready = rst_n ? ready : '0;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_cin   = alu_cin_q;
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_out1  = rsp_out1_q;
    assign bus.rsp_cout  = rsp_cout_q;
    assign bus.rsp_out2  = rsp_out2_q;

`ifdef ALU_SHARE_STATS_EN
    logic [NUM_REQ-1:0][STAT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ready[i] && cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign grant_cnt0 = cnt_q[0];
    assign grant_cnt1 = cnt_q[1];
`endif
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed bench for alu_share_ctrl with a scoreboard of
// expected responses. A behavioural adder/multiplier stands in for the ALU.
module tb_alu_share_ctrl;
    import alu_share_pkg::*;
    localparam int W = W_DEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_share_ctrl_if #(.W(W)) bus ();

`ifdef ALU_SHARE_STATS_EN
    logic [STAT_W-1:0] gc0, gc1;
    alu_share_ctrl #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus),
                                 .grant_cnt0(gc0), .grant_cnt1(gc1));
`else
    alu_share_ctrl #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    // ALU stand-in: Out1/Cout = A+B+Cin, Out2 = A*B
    assign {bus.alu_cout, bus.alu_out1} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {{W{1'b0}}, bus.alu_cin};
    assign bus.alu_out2 = {{W{1'b0}}, bus.alu_a} * {{W{1'b0}}, bus.alu_b};

    typedef struct packed {
        logic           id;
        logic [W-1:0]   out1;
        logic           cout;
        logic [2*W-1:0] out2;
    } rsp_t;

    rsp_t sb[$];
    int   acc_ids[$];
    int   acc_cyc[$];
    int   vectors = 0, miscompares = 0;
    int   cyc_no = 0, last_acc = 0;
    logic prev_rv = 1'b0;

    function automatic rsp_t ref_alu(logic id, logic [W-1:0] a, logic [W-1:0] b, logic cin);
        rsp_t r;
        int   s, p;
        s = int'(a) + int'(b) + int'(cin);
        p = int'(a) * int'(b);
        r.id   = id;
        r.out1 = W'(s % (1 << W));
        r.cout = (s >= (1 << W));
        r.out2 = p[2*W-1:0];
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample the cycle (accepts, responses, latency), then advance one clock.
    task automatic tick();
        rsp_t e;
        #2;
        if (rst_n) begin
            if (bus.rsp_valid) chk("ready_busy", 32'(bus.req_ready), 0);
            if (bus.req_valid[0] && bus.req_ready[0]) begin
                sb.push_back(ref_alu(1'b0, bus.req_a0, bus.req_b0, bus.req_cin0));
                acc_ids.push_back(0); acc_cyc.push_back(cyc_no); last_acc = cyc_no;
            end
            if (bus.req_valid[1] && bus.req_ready[1]) begin
                sb.push_back(ref_alu(1'b1, bus.req_a1, bus.req_b1, bus.req_cin1));
                acc_ids.push_back(1); acc_cyc.push_back(cyc_no); last_acc = cyc_no;
            end
            if (bus.rsp_valid && !prev_rv) chk("latency", cyc_no - last_acc, 2);
            if (bus.rsp_valid) begin
                if (sb.size() == 0) chk("rsp_unexpected", 32'(bus.rsp_valid), 0);
                else begin
                    e = sb[0];
                    chk("rsp_id",   32'(bus.rsp_id),   32'(e.id));
                    chk("rsp_out1", 32'(bus.rsp_out1), 32'(e.out1));
                    chk("rsp_cout", 32'(bus.rsp_cout), 32'(e.cout));
                    chk("rsp_out2", 32'(bus.rsp_out2), 32'(e.out2));
                    if (bus.rsp_ready) void'(sb.pop_front());
                end
            end
            prev_rv = bus.rsp_valid;
        end else prev_rv = 1'b0;
        @(posedge clk); #1;
        cyc_no++;
    endtask

    task automatic do_reset(int n);
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        repeat (n) tick();
        sb.delete(); acc_ids.delete(); acc_cyc.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(int bound);
        int n = 0;
        while (sb.size() != 0 && n < bound) begin tick(); n++; end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        bus.req_valid = '0; bus.rsp_ready = 1'b0;
        bus.req_a0 = '0; bus.req_b0 = '0; bus.req_cin0 = 1'b0;
        bus.req_a1 = '0; bus.req_b1 = '0; bus.req_cin1 = 1'b0;
        @(posedge clk); #1;

        // Reset values
        rst_n = 1'b0;
        repeat (2) tick();
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_id",    32'(bus.rsp_id), 0);
        chk("rst_rsp_out1",  32'(bus.rsp_out1), 0);
        chk("rst_rsp_cout",  32'(bus.rsp_cout), 0);
        chk("rst_rsp_out2",  32'(bus.rsp_out2), 0);
        chk("rst_alu_a",     32'(bus.alu_a), 0);
        chk("rst_alu_b",     32'(bus.alu_b), 0);
        chk("rst_alu_cin",   32'(bus.alu_cin), 0);
        rst_n = 1'b1;

        // Single request from requester 0: (3, 4, 1)
        bus.req_a0 = 4'd3; bus.req_b0 = 4'd4; bus.req_cin0 = 1'b1;
        bus.req_valid = 2'b01; bus.rsp_ready = 1'b1;
        #1 chk("t1_ready", 32'(bus.req_ready), 32'b01);
        tick();
        bus.req_valid = 2'b00;
        #1;
        chk("t1_exec_ready", 32'(bus.req_ready), 0);
        chk("t1_exec_valid", 32'(bus.rsp_valid), 0);
        chk("t1_alu_a",   32'(bus.alu_a), 3);
        chk("t1_alu_b",   32'(bus.alu_b), 4);
        chk("t1_alu_cin", 32'(bus.alu_cin), 1);
        tick();
        #1;
        chk("t1_valid", 32'(bus.rsp_valid), 1);
        chk("t1_id",    32'(bus.rsp_id), 0);
        chk("t1_out1",  32'(bus.rsp_out1), 8);
        chk("t1_cout",  32'(bus.rsp_cout), 0);
        chk("t1_out2",  32'(bus.rsp_out2), 12);
        tick();
        #1 chk("t1_done", 32'(bus.rsp_valid), 0);

        // Both requesters from reset: alternate 0,1,0,1 three cycles apart
        do_reset(1);
        bus.req_valid = 2'b11; bus.rsp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            bus.req_a0 = W'($urandom); bus.req_b0 = W'($urandom); bus.req_cin0 = 1'($urandom);
            bus.req_a1 = W'($urandom); bus.req_b1 = W'($urandom); bus.req_cin1 = 1'($urandom);
            tick();
        end
        bus.req_valid = 2'b00;
        wait_idle(10);
        chk("t2_count", acc_ids.size(), 4);
        for (int k = 0; k < 4 && k < acc_ids.size(); k++) chk("t2_order", acc_ids[k], k % 2);
        for (int k = 0; k + 1 < 4 && k + 1 < acc_cyc.size(); k++)
            chk("t2_spacing", acc_cyc[k+1] - acc_cyc[k], 3);

        // Back-pressure: response held 5 cycles, no accepts meanwhile
        bus.req_a0 = 4'd9; bus.req_b0 = 4'd7; bus.req_cin0 = 1'b1;
        bus.req_valid = 2'b01; bus.rsp_ready = 1'b0;
        tick();
        bus.req_valid = 2'b11;
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t3_valid", 32'(bus.rsp_valid), 1);
            chk("t3_ready", 32'(bus.req_ready), 0);
            chk("t3_out1",  32'(bus.rsp_out1), 1);
            chk("t3_cout",  32'(bus.rsp_cout), 1);
            chk("t3_out2",  32'(bus.rsp_out2), 63);
            tick();
        end
        bus.req_valid = 2'b00; bus.rsp_ready = 1'b1;
        wait_idle(10);

        // Reset during EXEC discards the transaction
        bus.req_a1 = 4'd5; bus.req_b1 = 4'd6; bus.req_cin1 = 1'b0;
        bus.req_valid = 2'b10;
        tick();
        bus.req_valid = 2'b00;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb.delete();
        for (int k = 0; k < 3; k++) begin
            #1 chk("t4_no_rsp", 32'(bus.rsp_valid), 0);
            tick();
        end
        bus.req_a0 = 4'd15; bus.req_b0 = 4'd15; bus.req_cin0 = 1'b1;
        bus.req_valid = 2'b01;
        #1 chk("t4_accept", 32'(bus.req_ready), 32'b01);
        tick();
        bus.req_valid = 2'b00;
        wait_idle(10);

        // Requester 1 alone, four back-to-back transactions
        acc_ids.delete(); acc_cyc.delete();
        bus.req_valid = 2'b10; bus.rsp_ready = 1'b1;
        for (int k = 0; k < 40 && acc_ids.size() < 4; k++) begin
            bus.req_a1 = W'($urandom); bus.req_b1 = W'($urandom); bus.req_cin1 = 1'($urandom);
            tick();
        end
        bus.req_valid = 2'b00;
        wait_idle(10);
        chk("t5_count", acc_ids.size(), 4);
        for (int k = 0; k < acc_ids.size(); k++) chk("t5_id", acc_ids[k], 1);
        for (int k = 0; k + 1 < acc_cyc.size(); k++) chk("t5_spacing", acc_cyc[k+1] - acc_cyc[k], 3);

`ifdef ALU_SHARE_STATS_EN
        // 300 accepts on requester 0: counter saturates
        do_reset(1);
        bus.req_valid = 2'b01; bus.rsp_ready = 1'b1;
        for (int k = 0; k < 1200 && acc_ids.size() < 300; k++) tick();
        bus.req_valid = 2'b00;
        wait_idle(10);
        chk("t6_count", acc_ids.size(), 300);
        chk("t6_cnt0", 32'(gc0), 255);
        chk("t6_cnt1", 32'(gc1), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
